arb_req_agent: RTL

ARB_REQ_AGENT -- requirements
Module: arb_req_agent

---
 rtl/arb_req_agent.sv | 118 +++++++++++
 1 files changed

// File: rtl/arb_req_agent.sv
// Burst-aware arbiter requester: queues {data,last} beats, requests the shared
// bus once a complete burst is stored, and holds lock while a burst is granted.
module arb_req_agent #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              req,
  input  logic              gnt,
  output logic              lock,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              err_ovf,
  output logic              err_gnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  logic [DATA_W:0]   mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  burst_cnt;
  logic [CNT_W-1:0]  burst_nxt;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W:0]   head;
  logic              push;
  logic              pop;
  logic              push_last;
  logic              pop_last;

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign req       = (state != S_IDLE);
  assign lock      = (state == S_BURST);
  assign head      = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = gnt & (state != S_IDLE) & (count != '0);
  assign push_last = push & in_last;
  assign pop_last  = pop & head[DATA_W];
  // Post-push/post-pop count of complete bursts; drives the request decision.
  assign burst_nxt = burst_cnt + CNT_W'(push_last) - CNT_W'(pop_last);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (burst_nxt != '0) state_nxt = S_REQ;
      end
      S_REQ, S_BURST: begin
        if (pop_last)  state_nxt = (burst_nxt != '0) ? S_REQ : S_IDLE;
        else if (pop)  state_nxt = S_BURST;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      burst_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count + CNT_W'(push) - CNT_W'(pop);
      burst_cnt <= burst_nxt;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        out_data <= head[DATA_W-1:0];
        out_last <= head[DATA_W];
      end
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_gnt <= 1'b0;
    end else begin
      if ((count == CNT_W'(DEPTH)) && (burst_cnt == '0)) err_ovf <= 1'b1;
      if (gnt && (state == S_IDLE))                        err_gnt <= 1'b1;
    end
  end

endmodule
